// File: rtl/test_design_16x16.sv
// 16x16 float32 frame transposer: loads a frame in raster order, drains it column-major,
// and reports the position and value of the frame maximum after each full load.
module test_design_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        peak_valid,
  output logic [3:0]  peak_row,
  output logic [3:0]  peak_col,
  output logic [31:0] peak_value
);

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic        cand_ok_q, cand_ok_d;
  logic [31:0] cand_val_q, cand_val_d;
  logic [7:0]  cand_idx_q, cand_idx_d;
  logic        peak_valid_q, peak_valid_d;
  logic [3:0]  peak_row_q, peak_row_d;
  logic [3:0]  peak_col_q, peak_col_d;
  logic [31:0] peak_value_q, peak_value_d;
  logic [31:0] mem_q [256];
  logic        in_acc_s;
  logic        out_acc_s;
  logic        in_nan_s;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Strict numeric a > b for non-NaN floats; -0 is folded onto +0 so the zeros tie.
  function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb;
    sa = a[31] & (a[30:0] != 31'd0);
    sb = b[31] & (b[30:0] != 31'd0);
    if (sa != sb) begin
      return sb;
    end else if (!sa) begin
      return a[30:0] > b[30:0];
    end else begin
      return a[30:0] < b[30:0];
    end
  endfunction

  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == DRAIN);
  assign out_last   = out_valid & (rd_cnt_q == 8'd255);
  assign out_data   = mem_q[{rd_cnt_q[3:0], rd_cnt_q[7:4]}];
  assign peak_valid = peak_valid_q;
  assign peak_row   = peak_row_q;
  assign peak_col   = peak_col_q;
  assign peak_value = peak_value_q;
  assign in_acc_s   = in_valid & in_ready;
  assign out_acc_s  = out_valid & out_ready;
  assign in_nan_s   = is_nan(in_data);

  // Next-state, counter and peak-tracker logic.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    cand_ok_d    = cand_ok_q;
    cand_val_d   = cand_val_q;
    cand_idx_d   = cand_idx_q;
    peak_valid_d = 1'b0;
    peak_row_d   = peak_row_q;
    peak_col_d   = peak_col_q;
    peak_value_d = peak_value_q;
    if (in_acc_s) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
      // The first word of a frame restarts the search, so stale candidates never leak across frames.
      if (wr_cnt_q == 8'd0) begin
        cand_ok_d  = !in_nan_s;
        cand_val_d = in_data;
        cand_idx_d = 8'd0;
      end else if (!in_nan_s && (!cand_ok_q || f_gt(in_data, cand_val_q))) begin
        cand_ok_d  = 1'b1;
        cand_val_d = in_data;
        cand_idx_d = wr_cnt_q;
      end else begin
        cand_ok_d  = cand_ok_q;
      end
      if (wr_cnt_q == 8'd255) begin
        state_d      = DRAIN;
        wr_cnt_d     = 8'd0;
        peak_valid_d = 1'b1;
        peak_value_d = cand_ok_d ? cand_val_d : 32'h7FC0_0000;
        peak_row_d   = cand_ok_d ? cand_idx_d[7:4] : 4'd0;
        peak_col_d   = cand_ok_d ? cand_idx_d[3:0] : 4'd0;
      end else begin
        state_d      = state_q;
      end
    end else if (out_acc_s) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
      if (rd_cnt_q == 8'd255) begin
        state_d = LOAD;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control, candidate and peak-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      wr_cnt_q     <= 8'd0;
      rd_cnt_q     <= 8'd0;
      cand_ok_q    <= 1'b0;
      cand_val_q   <= 32'd0;
      cand_idx_q   <= 8'd0;
      peak_valid_q <= 1'b0;
      peak_row_q   <= 4'd0;
      peak_col_q   <= 4'd0;
      peak_value_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      cand_ok_q    <= cand_ok_d;
      cand_val_q   <= cand_val_d;
      cand_idx_q   <= cand_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_row_q   <= peak_row_d;
      peak_col_q   <= peak_col_d;
      peak_value_q <= peak_value_d;
    end
  end

  // Frame buffer: never reset, written only by accepted input words.
  always_ff @(posedge clk) begin
    if (!rst && in_acc_s) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_test_design_16x16.sv
// Directed + randomized bench for test_design_16x16 with a real-valued reference model
// for the peak search and an index-arithmetic model for the transposed drain order.
module tb_test_design_16x16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        peak_valid;
  logic [3:0]  peak_row;
  logic [3:0]  peak_col;
  logic [31:0] peak_value;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] frame [256];
  logic [31:0] exp_pv;
  logic [3:0]  exp_pr, exp_pc;
  logic        prev_stall;
  logic [31:0] prev_data;

  always #5 clk = ~clk;

  test_design_16x16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .peak_valid(peak_valid), .peak_row(peak_row), .peak_col(peak_col), .peak_value(peak_value)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] int2f(input int i);
    int p;
    if (i == 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 31; b++) if (((i >> b) & 1) != 0) p = b;
    return {1'b0, 8'(127 + p), 23'((i << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic bit nan_w(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Numeric value of a non-NaN float32; infinities map beyond the finite range.
  function automatic real f2r(input logic [31:0] v);
    int  e;
    real r;
    if (v[30:23] == 8'hFF) return v[31] ? -1.0e300 : 1.0e300;
    e = (v[30:23] == 8'd0) ? 1 : int'(v[30:23]);
    r = (v[30:23] == 8'd0) ? real'(v[22:0]) : real'(v[22:0]) + 8388608.0;
    for (int s = 0; s < e - 150; s++) r = r * 2.0;
    for (int s = 0; s < 150 - e; s++) r = r * 0.5;
    return v[31] ? -r : r;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    case ($urandom_range(0, 6))
      0: w = $urandom;
      1: w = int2f($urandom_range(0, 255)) | {$urandom_range(0, 1) == 1, 31'd0};
      2: w = {$urandom_range(0, 1) == 1, 31'd0};
      3: w = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
      4: w = {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
      default: w = int2f($urandom_range(0, 3)) | {$urandom_range(0, 1) == 1, 31'd0};
    endcase
    return w;
  endfunction

  // Reference peak: largest numeric value, earliest index on ties, NaNs skipped.
  task automatic compute_peak();
    int best = -1;
    for (int i = 0; i < 256; i++)
      if (!nan_w(frame[i]) && (best < 0 || f2r(frame[i]) > f2r(frame[best]))) best = i;
    exp_pv = (best < 0) ? 32'h7FC0_0000 : frame[best];
    exp_pr = (best < 0) ? 4'd0 : 4'(best / 16);
    exp_pc = (best < 0) ? 4'd0 : 4'(best % 16);
  endtask

  task automatic load_frame(input int n, input bit rand_v);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_valid = rand_v ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? frame[acc] : $urandom;
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_out_valid", 32'(out_valid), 32'd0);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
    end
    if (acc < n) chk("load_timeout", 32'(acc), 32'(n));
  endtask

  task automatic check_peak();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("peak_valid_pulse", 32'(peak_valid), 32'd1);
    chk("peak_row", 32'(peak_row), 32'(exp_pr));
    chk("peak_col", 32'(peak_col), 32'(exp_pc));
    chk("peak_value", peak_value, exp_pv);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    prev_stall = 1'b1;
    prev_data  = out_data;
  endtask

  task automatic drain_frame(input int n, input bit rand_r);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      out_ready = rand_r ? ($urandom_range(0, 1) == 1) : 1'b1;
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_peak_valid", 32'(peak_valid), 32'd0);
      chk("peak_hold", {peak_row, peak_col, peak_value[23:0]}, {exp_pr, exp_pc, exp_pv[23:0]});
      if (prev_stall) chk("stall_stable", out_data, prev_data);
      chk("out_data", out_data, frame[(k % 16) * 16 + k / 16]);
      chk("out_last", 32'(out_last), 32'(k == 255));
      prev_stall = !out_ready;
      prev_data  = out_data;
      if (out_ready) k++;
      @(posedge clk);
    end
    if (k < n) chk("drain_timeout", 32'(k), 32'(n));
    prev_stall = 1'b0;
  endtask

  task automatic after_drain();
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_out_last", 32'(out_last), 32'd0);
    chk("post_peak_valid", 32'(peak_valid), 32'd0);
  endtask

  task automatic run_frame(input bit rand_v, input bit rand_r);
    compute_peak();
    load_frame(256, rand_v);
    check_peak();
    drain_frame(256, rand_r);
    after_drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = $urandom;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_pv = 32'd0;
    exp_pr = 4'd0;
    exp_pc = 4'd0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_peak_valid", 32'(peak_valid), 32'd0);
    chk("rst_peak", {20'd0, peak_row, peak_col, 4'd0}, 32'd0);
    chk("rst_peak_value", peak_value, 32'd0);
  endtask

  initial begin
    prev_stall = 1'b0;
    prev_data  = 32'd0;
    do_reset();

    for (int i = 0; i < 256; i++) frame[i] = int2f(i);
    run_frame(1'b0, 1'b0);

    for (int i = 0; i < 256; i++) frame[i] = 32'hBF80_0000;
    frame[37] = 32'hBF00_0000;
    run_frame(1'b1, 1'b1);

    for (int i = 0; i < 256; i++) frame[i] = 32'd0;
    frame[10]  = 32'h4040_0000;
    frame[200] = 32'h4040_0000;
    frame[50]  = 32'h7FC0_0001;
    run_frame(1'b1, 1'b1);

    for (int i = 0; i < 256; i++) frame[i] = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
    run_frame(1'b1, 1'b1);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 256; i++) frame[i] = rnd_word();
      run_frame(1'b1, 1'b1);
    end

    for (int i = 0; i < 256; i++) frame[i] = rnd_word();
    compute_peak();
    load_frame(256, 1'b1);
    check_peak();
    drain_frame(60, 1'b1);
    do_reset();

    for (int i = 0; i < 256; i++) frame[i] = rnd_word();
    load_frame(100, 1'b1);
    do_reset();
    for (int i = 0; i < 256; i++) frame[i] = int2f(i);
    run_frame(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
